result_writeback: RTL and testbench
===================================

// Module: result_writeback
// PURPOSE
//  Downstream drain stage of the matrix-vector systolic array. While the array controller holds
//  `read` high, captures one accumulator result per cycle and requantises it (arithmetic shift,
//  signed saturation). Buffers results in a FIFO and writes them into the shared buffer memory
//  at base_addr_i + k. Signals completion and sticky error status to the host CSR block.
// PARAMETERS
//  ADDR_SIZE   10   buffer-memory address width
//  PE_NUMBER   64   max results per run; FIFO depth
//  ACC_WIDTH   32   signed accumulator width from the array
//  DATA_WIDTH  16   signed width written to memory
// PORTS
//  clk          in   1           system clock, all state on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  read_i       in   1           controller READ phase; res_i valid every cycle it is high
//  res_i        in   ACC_WIDTH   signed result from array column output
//  col_size_i   in   8           result count for this run; sampled on read_i rising edge
//  base_addr_i  in   ADDR_SIZE   first write address; sampled on read_i rising edge
//  shift_i      in   5           right-shift amount; sampled on read_i rising edge
//  clr_i        in   1           clears ovf_o/sat_o/done_o (host write)
//  wr_en_o      out  1           memory write request (valid)
//  wr_addr_o    out  ADDR_SIZE   write address
//  wr_data_o    out  DATA_WIDTH  write data
//  wr_ready_i   in   1           memory arbiter accepts write this cycle
//  busy_o       out  1           run in progress (not IDLE)
//  done_o       out  1           sticky: run completed, all writes accepted
//  ovf_o        out  1           sticky: sample dropped (FIFO full or count > col_size)
//  sat_o        out  1           sticky: at least one result saturated
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; counters 0. Reset mid-run aborts with no writes.
//  Requant: r = res_i >>> shift_i (arithmetic). Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//    On clamp, set sat_o. Done combinationally before the FIFO push.
//  Capture: each cycle with read_i=1 and in_cnt < col_size, push into FIFO; in_cnt++.
//    If FIFO full, or in_cnt >= col_size, drop the sample, set ovf_o, and leave in_cnt unchanged.
//  Write: valid/ready. wr_en_o=1 whenever FIFO is non-empty. Addr/data stay stable until wr_ready_i=1.
//    On accept: pop; wr_addr_o = base + out_cnt, modulo 2^ADDR_SIZE (wrap allowed); out_cnt++.
//  Latency: sample pushed on edge N appears on wr_en_o/wr_data_o after edge N (cycle N+1).
//  Simultaneous push+pop on a full FIFO: pop frees a slot, push succeeds, no ovf.
//  FSM (enum in package):
//    IDLE    -> COLLECT on read_i rising edge; latches config; in_cnt = out_cnt = 0; clears done_o.
//    COLLECT -> DRAIN when read_i falls.
//    DRAIN   -> DONE when FIFO empty and no write pending.
//    DONE    -> IDLE after one cycle; sets done_o.
//  read_i rising in DRAIN/DONE (new run before drain): ignored, set ovf_o.
//  col_size_i = 0: collect nothing; run still passes DRAIN -> DONE; done_o set.
//  clr_i has priority over same-cycle sticky set.
// STRUCTURE
//  matrix_pkg: wb_state_t enum {IDLE, COLLECT, DRAIN, DONE}; ADDR_SIZE/ACC_WIDTH/DATA_WIDTH defaults;
//    requant function sat_shift().
//  Sub-module result_fifo (sync FIFO: DEPTH=PE_NUMBER, WIDTH=DATA_WIDTH, full/empty/count,
//    same-cycle push+pop).
//  Top level holds FSM, counters, config latches and sticky flags.
// TESTING
//  1 col=4, base=0x100, shift=0, res 1,2,3,4, ready=1
//      -> writes (0x100,1)..(0x103,4) on consecutive cycles; done_o=1; busy_o=0.
//  2 shift=4, res 0x7FFF_FFFF and -0x8000_0000
//      -> data 0x7FFF and 0x8000; sat_o=1. Res 0x100 -> 0x0010, sat unaffected.
//  3 col=64, ready held 0 during read, then 1
//      -> 64 writes, no ovf; wr_addr/data stable during stall; raising ready mid-run loses nothing.
//  4 col=3, read_i high 5 cycles
//      -> exactly 3 writes; ovf_o=1; clr_i clears ovf_o/done_o.
//  5 base=0x3FE, col=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
//  6 reset_n low mid-DRAIN with 10 queued -> wr_en_o=0 immediately; busy_o=0; next run from empty.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types, default widths and the requantisation helper for the
// matrix-vector array drain path.
package matrix_pkg;

    localparam int DEF_ADDR_SIZE  = 10;
    localparam int DEF_PE_NUMBER  = 64;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } wb_state_t;

    // Requantised sample plus a flag telling whether it had to be clamped.
    typedef struct packed {
        logic                      sat;
        logic [DEF_DATA_WIDTH-1:0] data;
    } rq_t;

    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MAX =
        DEF_ACC_WIDTH'((1 << (DEF_DATA_WIDTH - 1)) - 1);
    // Bitwise complement of 2^(N-1)-1 is -2^(N-1).
    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Arithmetic right shift followed by signed saturation to DATA_WIDTH.
    function automatic rq_t sat_shift(input logic signed [DEF_ACC_WIDTH-1:0] v,
                                      input logic [4:0]                      sh);
        logic signed [DEF_ACC_WIDTH-1:0] r;
        rq_t o;
        r      = v >>> sh;
        o.sat  = 1'b0;
        o.data = r[DEF_DATA_WIDTH-1:0];
        if (r > SAT_MAX) begin
            o.sat  = 1'b1;
            o.data = SAT_MAX[DEF_DATA_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            o.sat  = 1'b1;
            o.data = SAT_MIN[DEF_DATA_WIDTH-1:0];
        end
        return o;
    endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Write port into the shared buffer memory (valid/ready).
interface result_writeback_if #(
    parameter int ADDR_SIZE  = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO with same-cycle push/pop; a pop lets a push into a full FIFO.
module result_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/result_writeback.sv
// Drain stage of the systolic array: requantises results during the READ
// phase, buffers them and writes them to buffer memory at base + k.
module result_writeback
    import matrix_pkg::*;
#(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int PE_NUMBER  = DEF_PE_NUMBER,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        read_i,
    input  logic signed [ACC_WIDTH-1:0] res_i,
    input  logic [7:0]                  col_size_i,
    input  logic [ADDR_SIZE-1:0]        base_addr_i,
    input  logic [4:0]                  shift_i,
    input  logic                        clr_i,
    result_writeback_if.master          wr,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        ovf_o,
    output logic                        sat_o
);

    localparam int CW = $clog2(PE_NUMBER + 1);

    wb_state_t             state_q, state_d;
    logic                  read_q;
    logic [7:0]            col_q, col_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [ADDR_SIZE-1:0]  base_q, base_d;
    logic [4:0]            shift_q, shift_d;
    logic                  done_q, done_d, ovf_q, ovf_d, sat_q, sat_d;

    logic                  rise, start, win, push, pop, drop, late_start;
    logic [7:0]            col_eff, cnt_eff;
    logic [4:0]            shift_eff;
    rq_t                   rq;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    // The rising-edge sample is captured too, so config is taken straight
    // from the inputs in that cycle and from the latches afterwards.
    assign rise       = read_i && !read_q;
    assign start      = (state_q == IDLE) && rise;
    assign late_start = rise && (state_q == DRAIN || state_q == DONE);
    assign win        = read_i && (start || state_q == COLLECT);
    assign col_eff    = start ? col_size_i : col_q;
    assign cnt_eff    = start ? 8'd0 : in_cnt_q;
    assign shift_eff  = start ? shift_i : shift_q;
    assign rq         = sat_shift(res_i, shift_eff);
    assign pop        = !fifo_empty && wr.wr_ready;
    assign push       = win && (cnt_eff < col_eff) && (!fifo_full || pop);
    assign drop       = win && !push;

    result_fifo #(.DEPTH(PE_NUMBER), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (rq.data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign wr.wr_en   = !fifo_empty;
    assign wr.wr_data = fifo_data;
    assign wr.wr_addr = base_q + ADDR_SIZE'(out_cnt_q);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign ovf_o      = ovf_q;
    assign sat_o      = sat_q;

    // FSM next state, config latches, counters and sticky status.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        base_d    = base_q;
        shift_d   = shift_q;
        in_cnt_d  = push ? cnt_eff + 8'd1 : cnt_eff;
        out_cnt_d = pop ? out_cnt_q + 8'd1 : out_cnt_q;
        done_d    = done_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = COLLECT;
                col_d     = col_size_i;
                base_d    = base_addr_i;
                shift_d   = shift_i;
                out_cnt_d = 8'd0;
                done_d    = 1'b0;
            end
            COLLECT: if (!read_i) state_d = DRAIN;
            DRAIN: if (fifo_cnt == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_q || drop || late_start;
        sat_d = sat_q || (push && rq.sat);
        // A host clear wins over any flag set in the same cycle.
        if (clr_i) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            sat_d  = 1'b0;
        end
    end

    // State registers; reset aborts any run and clears status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            col_q     <= '0;
            base_q    <= '0;
            shift_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_i;
            col_q     <= col_d;
            base_q    <= base_d;
            shift_q   <= shift_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: accepted writes are logged on the
// falling edge and compared against hand-computed address/data tables.
module tb_result_writeback;

    logic               clk = 1'b0;
    logic               reset_n, read_i, clr_i;
    logic signed [31:0] res_i;
    logic [7:0]         col_size_i;
    logic [9:0]         base_addr_i;
    logic [4:0]         shift_i;
    logic               busy_o, done_o, ovf_o, sat_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [9:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;
    wr_t         wq[$];
    logic [31:0] stim[$];

    always #5 clk = ~clk;

    result_writeback_if #(.ADDR_SIZE(10), .DATA_WIDTH(16)) wb ();

    result_writeback dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .read_i      (read_i),
        .res_i       (res_i),
        .col_size_i  (col_size_i),
        .base_addr_i (base_addr_i),
        .shift_i     (shift_i),
        .clr_i       (clr_i),
        .wr          (wb),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .sat_o       (sat_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write the memory side accepts on the coming edge.
    always @(negedge clk) begin
        wr_t w;
        if (reset_n && wb.wr_en && wb.wr_ready) begin
            w.a = wb.wr_addr;
            w.d = wb.wr_data;
            w.c = cyc;
            wq.push_back(w);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_read(input int n, input logic [7:0] col, input logic [9:0] base,
                            input logic [4:0] sh);
        col_size_i  = col;
        base_addr_i = base;
        shift_i     = sh;
        for (int i = 0; i < n; i++) begin
            read_i = 1'b1;
            res_i  = (i < stim.size()) ? stim[i] : 32'd0;
            step();
        end
        read_i = 1'b0;
        res_i  = '0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 400 && busy_o; k++) step();
        tests++;
        if (busy_o !== 1'b0) begin
            $display("FAIL %s_timeout: busy_o=%b want 0", name, busy_o);
            fails++;
        end
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; read_i = 1'b0; clr_i = 1'b0; res_i = '0;
        col_size_i = '0; base_addr_i = '0; shift_i = '0; wb.wr_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        tests++;
        if (wb.wr_en !== 1'b0) begin
            $display("FAIL reset_wr_en: got %b want 0", wb.wr_en); fails++;
        end
        tests++;
        if ({busy_o, done_o, ovf_o, sat_o} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, ovf_o, sat_o}); fails++;
        end
    endtask

    task automatic test_basic();
        wq.delete();
        wb.wr_ready = 1'b1;
        stim = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_read(4, 8'd4, 10'h100, 5'd0);
        wait_idle("basic");
        tests++;
        if (wq.size() !== 4) begin
            $display("FAIL basic_count: got %0d want 4", wq.size()); fails++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (wq[i].a !== 10'('h100 + i) || wq[i].d !== 16'(i + 1) || wq[i].c !== wq[0].c + i) begin
                    $display("FAIL basic_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i,
                             wq[i].a, wq[i].d, wq[i].c, 10'('h100 + i), 16'(i + 1), wq[0].c + i);
                    fails++;
                end
            end
        end
        tests++;
        if ({done_o, busy_o, ovf_o, sat_o} !== 4'b1000) begin
            $display("FAIL basic_flags: got %b want 1000", {done_o, busy_o, ovf_o, sat_o}); fails++;
        end
    endtask

    task automatic test_requant();
        pulse_clr();
        wq.delete();
        stim = '{32'h0000_0100};
        run_read(1, 8'd1, 10'h000, 5'd4);
        wait_idle("rq_small");
        tests++;
        if (wq.size() !== 1 || wq[0].d !== 16'h0010 || sat_o !== 1'b0) begin
            $display("FAIL rq_small: got n=%0d d=%h sat=%b want n=1 d=0010 sat=0",
                     wq.size(), (wq.size() > 0) ? wq[0].d : 16'hxxxx, sat_o);
            fails++;
        end
        wq.delete();
        stim = '{32'h7FFF_FFFF, 32'h8000_0000};
        run_read(2, 8'd2, 10'h020, 5'd4);
        wait_idle("rq_sat");
        tests++;
        if (wq.size() !== 2 || wq[0].d !== 16'h7FFF || wq[1].d !== 16'h8000) begin
            $display("FAIL rq_sat_data: got n=%0d want 7fff,8000", wq.size()); fails++;
        end
        tests++;
        if (sat_o !== 1'b1) begin
            $display("FAIL rq_sat_flag: got %b want 1", sat_o); fails++;
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        pulse_clr();
        wq.delete();
        wb.wr_ready = 1'b0;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(32'(i * 3 + 7));
        col_size_i = 8'd64; base_addr_i = 10'h040; shift_i = 5'd0;
        for (int i = 0; i < 68; i++) begin
            read_i = (i < 64);
            res_i  = (i < 64) ? stim[i] : 32'd0;
            step();
            if (wb.wr_en !== 1'b1 || wb.wr_addr !== 10'h040 || wb.wr_data !== 16'd7) bad++;
        end
        tests++;
        if (bad !== 0) begin
            $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); fails++;
        end
        wb.wr_ready = 1'b1;
        wait_idle("stall");
        tests++;
        if (wq.size() !== 64) begin
            $display("FAIL stall_count: got %0d want 64", wq.size()); fails++;
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++)
                if (wq[i].a !== 10'('h040 + i) || wq[i].d !== 16'(i * 3 + 7)) bad++;
            tests++;
            if (bad !== 0) begin
                $display("FAIL stall_data: got %0d wrong writes want 0", bad); fails++;
            end
        end
        tests++;
        if (ovf_o !== 1'b0) begin
            $display("FAIL stall_ovf: got %b want 0", ovf_o); fails++;
        end
    endtask

    task automatic test_overrun();
        pulse_clr();
        wq.delete();
        stim = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
        run_read(5, 8'd3, 10'h200, 5'd0);
        wait_idle("ovr");
        tests++;
        if (wq.size() !== 3 || wq[0].d !== 16'd10 || wq[1].d !== 16'd11 || wq[2].d !== 16'd12) begin
            $display("FAIL ovr_writes: got n=%0d want 3 writes 10,11,12", wq.size()); fails++;
        end
        tests++;
        if ({ovf_o, done_o} !== 2'b11) begin
            $display("FAIL ovr_flags: got %b want 11", {ovf_o, done_o}); fails++;
        end
        pulse_clr();
        tests++;
        if ({ovf_o, done_o} !== 2'b00) begin
            $display("FAIL ovr_clr: got %b want 00", {ovf_o, done_o}); fails++;
        end
    endtask

    task automatic test_wrap();
        wq.delete();
        stim = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        run_read(4, 8'd4, 10'h3FE, 5'd0);
        wait_idle("wrap");
        tests++;
        if (wq.size() !== 4 || wq[0].a !== 10'h3FE || wq[1].a !== 10'h3FF ||
            wq[2].a !== 10'h000 || wq[3].a !== 10'h001 || wq[2].d !== 16'h00A3) begin
            $display("FAIL wrap_addr: got n=%0d want 3fe,3ff,000,001", wq.size()); fails++;
        end
    endtask

    task automatic test_zero_col();
        pulse_clr();
        wq.delete();
        stim = '{32'd99};
        run_read(1, 8'd0, 10'h000, 5'd0);
        wait_idle("zero");
        tests++;
        if (wq.size() !== 0 || done_o !== 1'b1) begin
            $display("FAIL zero_col: got n=%0d done=%b want n=0 done=1", wq.size(), done_o); fails++;
        end
    endtask

    task automatic test_restart_in_drain();
        pulse_clr();
        wq.delete();
        wb.wr_ready = 1'b0;
        stim = '{32'd5, 32'd6};
        run_read(2, 8'd2, 10'h080, 5'd0);
        step();
        read_i = 1'b1; res_i = 32'd9;
        step();
        read_i = 1'b0; res_i = '0;
        step();
        tests++;
        if (ovf_o !== 1'b1) begin
            $display("FAIL restart_ovf: got %b want 1", ovf_o); fails++;
        end
        wb.wr_ready = 1'b1;
        wait_idle("restart");
        tests++;
        if (wq.size() !== 2 || wq[0].d !== 16'd5 || wq[1].d !== 16'd6 || done_o !== 1'b1) begin
            $display("FAIL restart_writes: got n=%0d done=%b want n=2 done=1", wq.size(), done_o); fails++;
        end
    endtask

    task automatic test_reset_mid_drain();
        pulse_clr();
        wq.delete();
        wb.wr_ready = 1'b0;
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(32'(100 + i));
        run_read(10, 8'd20, 10'h000, 5'd0);
        step();
        step();
        tests++;
        if ({wb.wr_en, busy_o} !== 2'b11) begin
            $display("FAIL rst_pre: got %b want 11", {wb.wr_en, busy_o}); fails++;
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({wb.wr_en, busy_o} !== 2'b00) begin
            $display("FAIL rst_async: got %b want 00", {wb.wr_en, busy_o}); fails++;
        end
        step();
        reset_n = 1'b1;
        wb.wr_ready = 1'b1;
        step();
        stim = '{32'h55, 32'h66};
        run_read(2, 8'd2, 10'h010, 5'd0);
        wait_idle("rst_next");
        tests++;
        if (wq.size() !== 2 || wq[0].a !== 10'h010 || wq[0].d !== 16'h0055 ||
            wq[1].a !== 10'h011 || wq[1].d !== 16'h0066) begin
            $display("FAIL rst_next_run: got n=%0d want (010,55),(011,66)", wq.size()); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_requant();
        test_stall();
        test_overrun();
        test_wrap();
        test_zero_col();
        test_restart_in_drain();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
